// File: rtl/multi_issue_scoreboard.sv
// ============================================================================
// Module      : multi_issue_scoreboard
// Description : Multi-port in-order-commit scoreboard. Accepts up to
//               NR_ISSUE_PORTS instructions per cycle, takes out-of-order
//               writebacks keyed by transaction ID and presents up to
//               NR_COMMIT_PORTS completed head entries for in-order commit.
//               Optional macro MULTI_ISSUE_SCOREBOARD_WB_BYPASS_EN forwards
//               same-cycle writebacks into the commit window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_issue_scoreboard #(
    parameter int NR_ENTRIES      = 8,
    parameter int NR_ISSUE_PORTS  = 2,
    parameter int NR_WB_PORTS     = 4,
    parameter int NR_COMMIT_PORTS = 2,
    parameter int DATA_WIDTH      = 64,
    parameter int TRANS_ID_BITS   = $clog2(NR_ENTRIES)
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  logic                                           flush_i,
    input  logic [NR_ISSUE_PORTS-1:0]                      issue_valid_i,
    input  logic [NR_ISSUE_PORTS-1:0][DATA_WIDTH-1:0]      issue_data_i,
    output logic [NR_ISSUE_PORTS-1:0]                      issue_ack_o,
    output logic [NR_ISSUE_PORTS-1:0][TRANS_ID_BITS-1:0]   issue_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                         wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]      wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][DATA_WIDTH-1:0]         wb_data_i,
    input  logic [NR_WB_PORTS-1:0]                         wb_ex_i,
    output logic [NR_COMMIT_PORTS-1:0]                     commit_valid_o,
    output logic [NR_COMMIT_PORTS-1:0][DATA_WIDTH-1:0]     commit_data_o,
    output logic [NR_COMMIT_PORTS-1:0]                     commit_ex_o,
    output logic [NR_COMMIT_PORTS-1:0][TRANS_ID_BITS-1:0]  commit_trans_id_o,
    input  logic [NR_COMMIT_PORTS-1:0]                     commit_ack_i,
    output logic                                           full_o,
    output logic [TRANS_ID_BITS:0]                         usage_o
);

    localparam int c_usage_w = TRANS_ID_BITS + 1;
    localparam logic [c_usage_w-1:0] c_entries     = c_usage_w'(NR_ENTRIES);
    localparam logic [c_usage_w-1:0] c_issue_ports = c_usage_w'(NR_ISSUE_PORTS);

    // Per-entry state
    logic [NR_ENTRIES-1:0]     r_valid;
    logic [NR_ENTRIES-1:0]     r_done;
    logic [NR_ENTRIES-1:0]     r_ex;
    logic [DATA_WIDTH-1:0]     r_payload [NR_ENTRIES];
    logic [DATA_WIDTH-1:0]     r_result  [NR_ENTRIES];
    logic [TRANS_ID_BITS-1:0]  r_head;
    logic [TRANS_ID_BITS-1:0]  r_tail;
    logic [c_usage_w-1:0]      r_usage;
    logic                      r_full;

    // Combinational helpers
    logic [c_usage_w-1:0]      w_free;
    logic [c_usage_w-1:0]      w_issue_cnt;
    logic [c_usage_w-1:0]      w_retire_cnt;
    logic [c_usage_w-1:0]      w_usage_nxt;
    logic [NR_COMMIT_PORTS-1:0] w_take;
    logic [NR_ENTRIES-1:0]     w_issue_hit;
    logic [DATA_WIDTH-1:0]     w_issue_data [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]     w_wb_hit;
    logic [DATA_WIDTH-1:0]     w_wb_data [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]     w_wb_ex;
    logic [NR_ENTRIES-1:0]     w_retire;

    assign usage_o = r_usage;
    assign full_o  = r_full;

    // Issue acceptance: contiguous from port 0, limited by free slots at cycle start
    always_comb begin
        logic w_prev;
        w_free      = c_entries - r_usage;
        w_prev      = 1'b1;
        w_issue_cnt = '0;
        issue_ack_o = '0;
        for (int k = 0; k < NR_ISSUE_PORTS; k++) begin
            issue_ack_o[k]      = issue_valid_i[k] & w_prev & (w_free > c_usage_w'(k));
            w_prev              = issue_ack_o[k];
            issue_trans_id_o[k] = r_tail + TRANS_ID_BITS'(k);
            w_issue_cnt         = w_issue_cnt + {{(c_usage_w-1){1'b0}}, issue_ack_o[k]};
        end
    end

    // Map acked issue ports onto buffer entries
    always_comb begin
        for (int e = 0; e < NR_ENTRIES; e++) begin
            w_issue_hit[e]  = 1'b0;
            w_issue_data[e] = r_payload[e];
            for (int k = 0; k < NR_ISSUE_PORTS; k++) begin
                if (issue_ack_o[k] && (issue_trans_id_o[k] == TRANS_ID_BITS'(e))) begin
                    w_issue_hit[e]  = 1'b1;
                    w_issue_data[e] = issue_data_i[k];
                end
            end
        end
    end

    // Writeback resolution per entry; later ports override earlier ones so the highest index wins
    always_comb begin
        for (int e = 0; e < NR_ENTRIES; e++) begin
            w_wb_hit[e]  = 1'b0;
            w_wb_data[e] = r_result[e];
            w_wb_ex[e]   = r_ex[e];
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (wb_valid_i[p] && r_valid[e] && (wb_trans_id_i[p] == TRANS_ID_BITS'(e))) begin
                    w_wb_hit[e]  = 1'b1;
                    w_wb_data[e] = wb_data_i[p];
                    w_wb_ex[e]   = wb_ex_i[p];
                end
            end
        end
    end

    // Commit window: ready prefix from head, plus the acked prefix that actually retires
    always_comb begin
        logic                     w_cv_prev;
        logic                     w_take_prev;
        logic                     w_done;
        logic [TRANS_ID_BITS-1:0] w_idx;
        w_cv_prev    = 1'b1;
        w_take_prev  = 1'b1;
        w_retire_cnt = '0;
        w_take       = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            w_idx                = r_head + TRANS_ID_BITS'(k);
            commit_trans_id_o[k] = w_idx;
`ifdef MULTI_ISSUE_SCOREBOARD_WB_BYPASS_EN
            w_done               = r_done[w_idx] | w_wb_hit[w_idx];
            commit_data_o[k]     = w_wb_data[w_idx];
            commit_ex_o[k]       = w_wb_ex[w_idx];
`else
            w_done               = r_done[w_idx];
            commit_data_o[k]     = r_result[w_idx];
            commit_ex_o[k]       = r_ex[w_idx];
`endif
            commit_valid_o[k]    = r_valid[w_idx] & w_done & w_cv_prev;
            w_cv_prev            = commit_valid_o[k];
            w_take[k]            = commit_valid_o[k] & commit_ack_i[k] & w_take_prev;
            w_take_prev          = w_take[k];
            w_retire_cnt         = w_retire_cnt + {{(c_usage_w-1){1'b0}}, w_take[k]};
        end
    end

    // Map retiring commit ports back onto buffer entries
    always_comb begin
        for (int e = 0; e < NR_ENTRIES; e++) begin
            w_retire[e] = 1'b0;
            for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
                if (w_take[k] && ((r_head + TRANS_ID_BITS'(k)) == TRANS_ID_BITS'(e))) begin
                    w_retire[e] = 1'b1;
                end
            end
        end
    end

    // Next occupancy; flush empties the buffer regardless of other activity
    always_comb begin
        w_usage_nxt = flush_i ? '0 : (r_usage + w_issue_cnt - w_retire_cnt);
    end

    // Control state: valid/done/ex bits, pointers, occupancy and registered full flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_done  <= '0;
            r_ex    <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_usage <= '0;
            r_full  <= 1'b0;
        end else begin
            if (flush_i) begin
                r_valid <= '0;
                r_done  <= '0;
                r_head  <= '0;
                r_tail  <= '0;
            end else begin
                for (int e = 0; e < NR_ENTRIES; e++) begin
                    if (w_retire[e]) begin
                        r_valid[e] <= 1'b0;
                    end else if (w_issue_hit[e]) begin
                        r_valid[e] <= 1'b1;
                        r_done[e]  <= 1'b0;
                        r_ex[e]    <= 1'b0;
                    end else if (w_wb_hit[e]) begin
                        r_done[e]  <= 1'b1;
                        r_ex[e]    <= w_wb_ex[e];
                    end
                end
                r_head <= r_head + TRANS_ID_BITS'(w_retire_cnt);
                r_tail <= r_tail + TRANS_ID_BITS'(w_issue_cnt);
            end
            r_usage <= w_usage_nxt;
            r_full  <= (c_entries - w_usage_nxt) < c_issue_ports;
        end
    end

    // Payload and result storage; contents only matter while the entry is valid
    always_ff @(posedge clk_i) begin
        for (int e = 0; e < NR_ENTRIES; e++) begin
            if (w_issue_hit[e]) begin
                r_payload[e] <= w_issue_data[e];
            end
            if (w_wb_hit[e]) begin
                r_result[e] <= w_wb_data[e];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_issue_scoreboard.sv
// ============================================================================
// Module      : tb_multi_issue_scoreboard
// Description : Randomized self-checking bench for multi_issue_scoreboard,
//               compared against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_issue_scoreboard;

    localparam int NE = 8;
    localparam int IP = 2;
    localparam int WP = 4;
    localparam int CP = 2;
    localparam int DW = 64;
    localparam int TB = 3;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    flush_i;
    logic [IP-1:0]           issue_valid_i;
    logic [IP-1:0][DW-1:0]   issue_data_i;
    logic [IP-1:0]           issue_ack_o;
    logic [IP-1:0][TB-1:0]   issue_trans_id_o;
    logic [WP-1:0]           wb_valid_i;
    logic [WP-1:0][TB-1:0]   wb_trans_id_i;
    logic [WP-1:0][DW-1:0]   wb_data_i;
    logic [WP-1:0]           wb_ex_i;
    logic [CP-1:0]           commit_valid_o;
    logic [CP-1:0][DW-1:0]   commit_data_o;
    logic [CP-1:0]           commit_ex_o;
    logic [CP-1:0][TB-1:0]   commit_trans_id_o;
    logic [CP-1:0]           commit_ack_i;
    logic                    full_o;
    logic [TB:0]             usage_o;

    multi_issue_scoreboard #(
        .NR_ENTRIES(NE), .NR_ISSUE_PORTS(IP), .NR_WB_PORTS(WP),
        .NR_COMMIT_PORTS(CP), .DATA_WIDTH(DW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_data_i(issue_data_i),
        .issue_ack_o(issue_ack_o), .issue_trans_id_o(issue_trans_id_o),
        .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i),
        .wb_data_i(wb_data_i), .wb_ex_i(wb_ex_i),
        .commit_valid_o(commit_valid_o), .commit_data_o(commit_data_o),
        .commit_ex_o(commit_ex_o), .commit_trans_id_o(commit_trans_id_o),
        .commit_ack_i(commit_ack_i), .full_o(full_o), .usage_o(usage_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: in-flight instructions in program order
    typedef struct {
        int          id;
        bit          done;
        logic [63:0] data;
        bit          ex;
    } ent_t;

    ent_t q[$];
    int   m_head;
    int   m_tail;

    // Compare every DUT output against the model, then advance the model by one clock
    task automatic step_and_check();
        int          free_slots;
        bit          prev;
        logic [IP-1:0] exp_ack;
        logic [CP-1:0] exp_cv;
        int          n_iss;
        int          n_ret;
        ent_t        e;

        free_slots = NE - q.size();
        prev = 1'b1;
        exp_ack = '0;
        n_iss = 0;
        for (int k = 0; k < IP; k++) begin
            exp_ack[k] = issue_valid_i[k] && prev && (free_slots > k);
            prev = exp_ack[k];
            if (exp_ack[k]) n_iss++;
        end
        check_eq("issue_ack", 64'(issue_ack_o), 64'(exp_ack));
        for (int k = 0; k < IP; k++)
            check_eq($sformatf("issue_id%0d", k), 64'(issue_trans_id_o[k]), 64'((m_tail + k) % NE));

        prev = 1'b1;
        exp_cv = '0;
        for (int k = 0; k < CP; k++) begin
            exp_cv[k] = prev && (k < q.size()) && q[k].done;
            prev = exp_cv[k];
        end
        check_eq("commit_valid", 64'(commit_valid_o), 64'(exp_cv));
        for (int k = 0; k < CP; k++) begin
            check_eq($sformatf("commit_id%0d", k), 64'(commit_trans_id_o[k]), 64'((m_head + k) % NE));
            if (exp_cv[k]) begin
                check_eq($sformatf("commit_data%0d", k), commit_data_o[k], q[k].data);
                check_eq($sformatf("commit_ex%0d", k), 64'(commit_ex_o[k]), 64'(q[k].ex));
            end
        end
        check_eq("usage", 64'(usage_o), 64'(q.size()));
        check_eq("full", 64'(full_o), 64'((NE - q.size()) < IP));

        if (flush_i) begin
            q.delete();
            m_head = 0;
            m_tail = 0;
            return;
        end
        n_ret = 0;
        while (n_ret < CP && exp_cv[n_ret] && commit_ack_i[n_ret]) n_ret++;
        for (int r = 0; r < n_ret; r++) void'(q.pop_front());
        m_head = (m_head + n_ret) % NE;
        for (int p = 0; p < WP; p++) begin
            if (wb_valid_i[p]) begin
                foreach (q[i]) begin
                    if (q[i].id == int'(wb_trans_id_i[p])) begin
                        q[i].done = 1'b1;
                        q[i].data = wb_data_i[p];
                        q[i].ex   = wb_ex_i[p];
                    end
                end
            end
        end
        for (int k = 0; k < n_iss; k++) begin
            e.id = (m_tail + k) % NE;
            e.done = 1'b0;
            e.data = '0;
            e.ex = 1'b0;
            q.push_back(e);
        end
        m_tail = (m_tail + n_iss) % NE;
    endtask

    task automatic idle_inputs();
        flush_i       = 1'b0;
        issue_valid_i = '0;
        issue_data_i  = '0;
        wb_valid_i    = '0;
        wb_trans_id_i = '0;
        wb_data_i     = '0;
        wb_ex_i       = '0;
        commit_ack_i  = '0;
    endtask

    initial begin
        q.delete();
        m_head = 0;
        m_tail = 0;
        idle_inputs();
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        check_eq("rst_issue_ack", 64'(issue_ack_o), 64'd0);
        check_eq("rst_commit_valid", 64'(commit_valid_o), 64'd0);
        check_eq("rst_full", 64'(full_o), 64'd0);
        check_eq("rst_usage", 64'(usage_o), 64'd0);
        check_eq("rst_id0", 64'(issue_trans_id_o[0]), 64'd0);
        check_eq("rst_id1", 64'(issue_trans_id_o[1]), 64'd1);
        rst_i = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit fill_phase;
            @(negedge clk_i);
            fill_phase = ((cyc / 150) % 2) == 0;
            flush_i = ($urandom_range(0, 59) == 0);
            issue_valid_i = IP'($urandom);
            for (int k = 0; k < IP; k++) issue_data_i[k] = {$urandom, $urandom};
            for (int p = 0; p < WP; p++) begin
                wb_valid_i[p]    = ($urandom_range(0, 2) == 0);
                wb_trans_id_i[p] = TB'($urandom);
                wb_data_i[p]     = {$urandom, $urandom};
                wb_ex_i[p]       = ($urandom_range(0, 3) == 0);
            end
            for (int k = 0; k < CP; k++)
                commit_ack_i[k] = fill_phase ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 7) != 0);
            #1;
            step_and_check();
        end

        @(negedge clk_i);
        idle_inputs();
        #1;
        step_and_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
